// File: rtl/press_decoder_pkg.sv
// press_decoder_pkg: shared state encodings and event codes for the press decoder and scoring logic.
package press_decoder_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [1:0] EVT_TAP   = 2'b01;
    localparam logic [1:0] EVT_PRESS = 2'b10;
    localparam logic [1:0] EVT_HOLD  = 2'b11;
endpackage

// File: rtl/press_decoder_sat_counter.sv
// sat_counter: W-bit up counter that saturates at all-ones instead of wrapping.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : q <= 0 (highest priority)
//   load1      : q <= 1
//   inc        : q <= q + 1, held at all-ones
//   q          : current count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load1,
    input  logic         inc,
    output logic [W-1:0] q
);
    logic [W-1:0] q_q, q_d;

    assign q = q_q;

    always_comb
        q_d = clear ? '0 : load1 ? W'(1) : (inc && q_q != '1) ? q_q + 1'b1 : q_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q_q <= '0;
        else        q_q <= q_d;
endmodule

// File: rtl/press_decoder.sv
// press_decoder: measures debounced button presses and reports classified tap/press/hold events on release.
//   sys_clk, rst_n : clock, asynchronous active-low reset
//   in             : debounced button level, 1 = pressed
//   evt_valid      : one-cycle strobe for a classified press
//   evt_type       : EVT_TAP / EVT_PRESS / EVT_HOLD, held until the next event
//   evt_len        : press length in cycles (saturated), held until the next event
//   holding        : current press has reached HOLD_MIN
//   busy           : a press is being measured
module press_decoder
    import press_decoder_pkg::*;
#(
    parameter int MIN_PRESS = 2_000_000,
    parameter int TAP_MAX   = 12_500_000,
    parameter int HOLD_MIN  = 50_000_000,
    parameter int CNT_W     = 30
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             in,
    output logic             evt_valid,
    output logic [1:0]       evt_type,
    output logic [CNT_W-1:0] evt_len,
    output logic             holding,
    output logic             busy
);
    localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_PRESS);
    localparam logic [CNT_W-1:0] TAP_C   = CNT_W'(TAP_MAX);
    localparam logic [CNT_W-1:0] HOLD_C  = CNT_W'(HOLD_MIN);
    localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD_MIN - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] evt_len_q, evt_len_d;
    logic [1:0]       evt_type_q, evt_type_d;
    logic             evt_valid_q, evt_valid_d;
    logic             measuring, released;

    assign measuring = state_q != IDLE;
    assign released  = measuring && !in;

    // The counter is cleared on release so IDLE always sees cnt = 0.
    sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (sys_clk),
        .rst_n (rst_n),
        .clear (released),
        .load1 (!measuring && in),
        .inc   (measuring && in),
        .q     (cnt)
    );

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE)
            state_d = in ? PRESS : IDLE;
        else if (!in)
            state_d = IDLE;
        // cnt + 1 reaching HOLD_MIN is the same as cnt == HOLD_MIN - 1; avoids an extra adder.
        else if (state_q == PRESS && cnt == HOLD_M1)
            state_d = HOLD;
        evt_valid_d = released && cnt >= MIN_C;
        evt_type_d  = !evt_valid_d ? evt_type_q :
                      cnt <= TAP_C ? EVT_TAP :
                      cnt < HOLD_C ? EVT_PRESS : EVT_HOLD;
        evt_len_d   = evt_valid_d ? cnt : evt_len_q;
    end

    always_ff @(posedge sys_clk or negedge rst_n)
        if (!rst_n) begin
            state_q     <= IDLE;
            evt_valid_q <= 1'b0;
            evt_type_q  <= 2'b00;
            evt_len_q   <= '0;
        end else begin
            state_q     <= state_d;
            evt_valid_q <= evt_valid_d;
            evt_type_q  <= evt_type_d;
            evt_len_q   <= evt_len_d;
        end

    assign evt_valid = evt_valid_q;
    assign evt_type  = evt_type_q;
    assign evt_len   = evt_len_q;
    assign holding   = state_q == HOLD;
    assign busy      = measuring;
endmodule

// File: tb/tb_press_decoder.sv
// tb_press_decoder: randomized scoreboard bench for press_decoder against a run-length reference model.
module tb_press_decoder;
    localparam int MIN_PRESS = 2;
    localparam int TAP_MAX   = 5;
    localparam int HOLD_MIN  = 10;
    localparam int CNT_W     = 4;
    localparam int SAT       = (1 << CNT_W) - 1;

    typedef struct {
        logic [1:0] t;
        int         len;
        int         cyc;
    } evt_t;

    logic             sys_clk = 1'b0;
    logic             rst_n   = 1'b0;
    logic             in      = 1'b1;
    logic             evt_valid;
    logic [1:0]       evt_type;
    logic [CNT_W-1:0] evt_len;
    logic             holding;
    logic             busy;

    int   errors = 0;
    int   checks = 0;
    int   run    = 0;
    int   cyc    = 0;
    evt_t exp_q[$];

    press_decoder #(
        .MIN_PRESS (MIN_PRESS),
        .TAP_MAX   (TAP_MAX),
        .HOLD_MIN  (HOLD_MIN),
        .CNT_W     (CNT_W)
    ) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .in        (in),
        .evt_valid (evt_valid),
        .evt_type  (evt_type),
        .evt_len   (evt_len),
        .holding   (holding),
        .busy      (busy)
    );

    always #5 sys_clk = ~sys_clk;

    initial
        if (!(MIN_PRESS >= 1 && MIN_PRESS <= TAP_MAX && TAP_MAX < HOLD_MIN && HOLD_MIN <= SAT))
            $fatal(1, "illegal configuration");

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic logic [1:0] classify(input int n);
        return n <= TAP_MAX ? 2'b01 : n < HOLD_MIN ? 2'b10 : 2'b11;
    endfunction

    // Reference model: length of the current run of high samples since the last low sample or reset.
    always @(posedge sys_clk or negedge rst_n)
        if (!rst_n)
            run = 0;
        else begin
            cyc++;
            if (in)
                run++;
            else begin
                if (run >= MIN_PRESS)
                    exp_q.push_back('{classify(run), run > SAT ? SAT : run, cyc});
                run = 0;
            end
        end

    // Monitor: compares live levels every cycle and pops expected events when the DUT strobes.
    logic [1:0] last_t = 2'b00;
    int         last_l = 0;
    always @(posedge sys_clk) begin
        evt_t e;
        #2;
        if (!rst_n) begin
            last_t = 2'b00;
            last_l = 0;
        end
        check("busy", int'(busy), int'(rst_n && run > 0));
        check("holding", int'(holding), int'(rst_n && run >= HOLD_MIN));
        if (evt_valid) begin
            if (exp_q.size() == 0)
                check("unexpected_evt", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("evt_type", int'(evt_type), int'(e.t));
                check("evt_len", int'(evt_len), e.len);
                check("evt_cycle", cyc, e.cyc);
                last_t = e.t;
                last_l = e.len;
            end
        end else begin
            if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                check("missing_evt", 0, 1);
                last_t = e.t;
                last_l = e.len;
            end
            check("evt_type_hold", int'(evt_type), int'(last_t));
            check("evt_len_hold", int'(evt_len), last_l);
        end
    end

    task automatic pulse(input int hi, input int lo);
        in = 1'b1;
        repeat (hi) @(negedge sys_clk);
        in = 1'b0;
        repeat (lo) @(negedge sys_clk);
    endtask

    initial begin
        repeat (3) @(negedge sys_clk);
        check("reset_evt_valid", int'(evt_valid), 0);
        check("reset_evt_len", int'(evt_len), 0);
        rst_n = 1'b1;
        pulse(3, 3);
        pulse(1, 3);
        pulse(3, 3);
        pulse(7, 3);
        pulse(20, 3);
        in = 1'b1;
        repeat (8) @(negedge sys_clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_busy", int'(busy), 0);
        check("async_holding", int'(holding), 0);
        check("async_evt_valid", int'(evt_valid), 0);
        @(negedge sys_clk);
        in = 1'b0;
        @(negedge sys_clk);
        rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        pulse(3, 1);
        pulse(4, 3);
        for (int i = 0; i < 40; i++)
            pulse($urandom_range(1, 20), $urandom_range(1, 3));
        repeat (4) @(negedge sys_clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
